// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and helpers for the PE result collection path.
package pe_pkg;
    localparam int BYTE_W = 8;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // A FIFO entry is {last, row_data}: the tile-end flag sits above the packed row.
    function automatic int entry_w(input int array_num);
        return BYTE_W * array_num + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with a count register and flush.
module sync_fifo_fwft import pe_pkg::*; #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = count_w(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_en, rd_en;

    assign wr_en = push & ~flush;
    assign rd_en = pop & ~flush;
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    // While empty the head slot is meaningless, so show the most recently written row instead.
    assign dout  = empty ? mem[AW'(wr_ptr - AW'(1))] : mem[rd_ptr];

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end
endmodule

// File: rtl/pe_result_collector.sv
// pe_result_collector: buffers finished PE rows, tags tile ends and reports dropped rows.
module pe_result_collector import pe_pkg::*; #(
    parameter int ARRAY_NUM = 3,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    localparam int DW = BYTE_W * ARRAY_NUM,
    localparam int CW = count_w(DEPTH)
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic             iCapture,
    input  logic [DW-1:0]    iResult,
    input  logic [CNT_W-1:0] iCfsRowsPerTile,
    input  logic             iFlush,
    input  logic             iClearStatus,
    output logic             oValid,
    input  logic             iReady,
    output logic [DW-1:0]    oData,
    output logic             oLast,
    output logic [CW-1:0]    oCount,
    output logic             oOverflow
);
    logic [CNT_W-1:0] rowcnt, rows_n;
    logic [DW:0]      din, dout;
    logic             full, empty, pop, push, drop, tag_last;

    assign rows_n   = (iCfsRowsPerTile == '0) ? CNT_W'(1) : iCfsRowsPerTile;
    // >= rather than == so a shrunken tile size mid-tile still closes the tile on the next row.
    assign tag_last = rowcnt >= rows_n - CNT_W'(1);
    assign pop      = ~empty & iReady;
    assign push     = iCapture & (~full | pop);
    assign drop     = iCapture & full & ~pop & ~iFlush;
    assign din      = {tag_last, iResult};
    assign oValid   = ~empty;
    assign {oLast, oData} = dout;

    sync_fifo_fwft #(.WIDTH(entry_w(ARRAY_NUM)), .DEPTH(DEPTH)) u_fifo (
        .iClk  (iClk),
        .iRstN (iRstN),
        .push  (push),
        .pop   (pop),
        .flush (iFlush),
        .din   (din),
        .dout  (dout),
        .count (oCount),
        .full  (full),
        .empty (empty)
    );

    // The row counter follows every producer row, dropped or not, to stay tile-aligned.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rowcnt    <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (iFlush) rowcnt <= '0;
            else if (iCapture) rowcnt <= tag_last ? '0 : rowcnt + CNT_W'(1);
            if (drop) oOverflow <= 1'b1;
            else if (iClearStatus) oOverflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_result_collector.sv
// tb_pe_result_collector: directed table, async reset check and random run against a queue model.
module tb_pe_result_collector;
    localparam int ARRAY_NUM = 3;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 8;
    localparam int DW        = 8 * ARRAY_NUM;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic             iClk = 1'b0;
    logic             iRstN = 1'b0;
    logic             iCapture = 1'b0;
    logic [DW-1:0]    iResult = '0;
    logic [CNT_W-1:0] iCfsRowsPerTile = '0;
    logic             iFlush = 1'b0;
    logic             iClearStatus = 1'b0;
    logic             iReady = 1'b0;
    logic             oValid;
    logic [DW-1:0]    oData;
    logic             oLast;
    logic [CW-1:0]    oCount;
    logic             oOverflow;

    pe_result_collector #(.ARRAY_NUM(ARRAY_NUM), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .iClk            (iClk),
        .iRstN           (iRstN),
        .iCapture        (iCapture),
        .iResult         (iResult),
        .iCfsRowsPerTile (iCfsRowsPerTile),
        .iFlush          (iFlush),
        .iClearStatus    (iClearStatus),
        .oValid          (oValid),
        .iReady          (iReady),
        .oData           (oData),
        .oLast           (oLast),
        .oCount          (oCount),
        .oOverflow       (oOverflow)
    );

    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;

    // Model: a queue of {last, row} entries, the producer's position within the tile, and the sticky flag.
    logic [DW:0] q[$];
    int          rc  = 0;
    bit          ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("valid", 32'(oValid), 32'(q.size() != 0));
        chk("count", 32'(oCount), 32'(q.size()));
        chk("overflow", 32'(oOverflow), 32'(ovf));
        if (q.size() != 0) begin
            chk("data", 32'(oData), 32'(q[0][DW-1:0]));
            chk("last", 32'(oLast), 32'(q[0][DW]));
        end
    endtask

    // Drives one cycle from a negedge, advances the model across the posedge, checks at the next negedge.
    task automatic cyc(input bit cap, input logic [DW-1:0] res, input logic [CNT_W-1:0] n,
                       input bit fl, input bit clr, input bit rdy);
        int sz, nn;
        bit pop_m, lst, dropped;
        iCapture = cap; iResult = res; iCfsRowsPerTile = n;
        iFlush = fl; iClearStatus = clr; iReady = rdy;
        sz = q.size();
        nn = (n == 0) ? 1 : int'(n);
        pop_m = (sz > 0) && rdy;
        dropped = 1'b0;
        @(posedge iClk);
        if (fl) begin
            q.delete();
            rc = 0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (cap) begin
                lst = (rc >= nn - 1);
                if (sz < DEPTH || pop_m) q.push_back({lst, res});
                else dropped = 1'b1;
                rc = lst ? 0 : rc + 1;
            end
        end
        if (dropped) ovf = 1'b1;
        else if (clr) ovf = 1'b0;
        @(negedge iClk);
        chk_model();
    endtask

    typedef struct {
        bit              cap;
        logic [DW-1:0]   res;
        logic [CNT_W-1:0] n;
        bit              fl;
        bit              clr;
        bit              rdy;
        int              e_count;
        logic [DW-1:0]   e_data;
        bit              e_last;
        bit              e_ovf;
    } vec_t;

    vec_t v[$];

    function automatic vec_t mk(bit cap, logic [DW-1:0] res, logic [CNT_W-1:0] n, bit fl, bit clr,
                                bit rdy, int e_count, logic [DW-1:0] e_data, bit e_last, bit e_ovf);
        vec_t r;
        r.cap = cap; r.res = res; r.n = n; r.fl = fl; r.clr = clr; r.rdy = rdy;
        r.e_count = e_count; r.e_data = e_data; r.e_last = e_last; r.e_ovf = e_ovf;
        return r;
    endfunction

    initial begin
        //           cap res       n  fl clr rdy cnt data      last ovf
        v.push_back(mk(1, 24'h030201, 2, 0, 0, 1, 1, 24'h030201, 0, 0));
        v.push_back(mk(1, 24'h060504, 2, 0, 0, 1, 1, 24'h060504, 1, 0));
        v.push_back(mk(0, 24'h0,      2, 0, 0, 1, 0, 24'h0,      0, 0));
        v.push_back(mk(1, 24'h11,     4, 0, 0, 0, 1, 24'h11,     0, 0));
        v.push_back(mk(1, 24'h22,     4, 0, 0, 0, 2, 24'h11,     0, 0));
        v.push_back(mk(1, 24'h33,     4, 0, 0, 0, 3, 24'h11,     0, 0));
        v.push_back(mk(1, 24'h44,     4, 0, 0, 0, 4, 24'h11,     0, 0));
        v.push_back(mk(1, 24'h55,     4, 0, 0, 0, 4, 24'h11,     0, 1));
        v.push_back(mk(0, 24'h0,      4, 0, 0, 1, 3, 24'h22,     0, 1));
        v.push_back(mk(0, 24'h0,      4, 0, 0, 1, 2, 24'h33,     0, 1));
        v.push_back(mk(0, 24'h0,      4, 0, 0, 1, 1, 24'h44,     1, 1));
        v.push_back(mk(0, 24'h0,      4, 0, 0, 1, 0, 24'h0,      0, 1));
        // Dropped 0x55 was row 0, so 0x66 is row 1: last when the tile is two rows.
        v.push_back(mk(1, 24'h66,     2, 0, 0, 0, 1, 24'h66,     1, 1));
        v.push_back(mk(0, 24'h0,      2, 0, 1, 1, 0, 24'h0,      0, 0));
        v.push_back(mk(1, 24'hA1,     4, 0, 0, 0, 1, 24'hA1,     0, 0));
        v.push_back(mk(1, 24'hA2,     4, 0, 0, 0, 2, 24'hA1,     0, 0));
        v.push_back(mk(1, 24'hA3,     4, 0, 0, 0, 3, 24'hA1,     0, 0));
        v.push_back(mk(1, 24'hA4,     4, 0, 0, 0, 4, 24'hA1,     0, 0));
        v.push_back(mk(1, 24'hA5,     4, 0, 0, 1, 4, 24'hA2,     0, 0));
        v.push_back(mk(0, 24'h0,      4, 0, 0, 1, 3, 24'hA3,     0, 0));
        v.push_back(mk(1, 24'hB1,     4, 1, 0, 1, 0, 24'h0,      0, 0));
        v.push_back(mk(1, 24'hC1,     2, 0, 0, 0, 1, 24'hC1,     0, 0));
        v.push_back(mk(1, 24'hC2,     2, 0, 0, 0, 2, 24'hC1,     0, 0));
        v.push_back(mk(1, 24'hC3,     2, 0, 0, 0, 3, 24'hC1,     0, 0));
        v.push_back(mk(1, 24'hC4,     2, 0, 0, 0, 4, 24'hC1,     0, 0));
        v.push_back(mk(1, 24'hD1,     2, 0, 0, 0, 4, 24'hC1,     0, 1));
        v.push_back(mk(1, 24'hD2,     2, 0, 1, 0, 4, 24'hC1,     0, 1));
        v.push_back(mk(0, 24'h0,      2, 0, 1, 0, 4, 24'hC1,     0, 0));
        v.push_back(mk(0, 24'h0,      2, 0, 0, 1, 3, 24'hC2,     1, 0));
        v.push_back(mk(0, 24'h0,      2, 0, 0, 1, 2, 24'hC3,     0, 0));
        v.push_back(mk(0, 24'h0,      2, 0, 0, 1, 1, 24'hC4,     1, 0));
        v.push_back(mk(0, 24'h0,      2, 0, 0, 1, 0, 24'h0,      0, 0));
        v.push_back(mk(1, 24'hAA,     0, 0, 0, 0, 1, 24'hAA,     1, 0));
        v.push_back(mk(1, 24'hBB,     0, 0, 0, 0, 2, 24'hAA,     1, 0));
        v.push_back(mk(0, 24'h0,      0, 0, 0, 1, 1, 24'hBB,     1, 0));
        v.push_back(mk(1, 24'hCC,     0, 0, 0, 0, 2, 24'hBB,     1, 0));

        repeat (3) @(negedge iClk);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_count", 32'(oCount), 0);
        chk("rst_ovf", 32'(oOverflow), 0);
        chk("rst_data", 32'(oData), 0);
        chk("rst_last", 32'(oLast), 0);
        iRstN = 1'b1;

        foreach (v[i]) begin
            cyc(v[i].cap, v[i].res, v[i].n, v[i].fl, v[i].clr, v[i].rdy);
            chk($sformatf("vec%0d_count", i), 32'(oCount), 32'(v[i].e_count));
            chk($sformatf("vec%0d_valid", i), 32'(oValid), 32'(v[i].e_count != 0));
            chk($sformatf("vec%0d_ovf", i), 32'(oOverflow), 32'(v[i].e_ovf));
            if (v[i].e_count != 0) begin
                chk($sformatf("vec%0d_data", i), 32'(oData), 32'(v[i].e_data));
                chk($sformatf("vec%0d_last", i), 32'(oLast), 32'(v[i].e_last));
            end
        end

        // Asynchronous reset mid-stream must clear outputs without a clock edge.
        #2 iRstN = 1'b0;
        #1;
        chk("async_valid", 32'(oValid), 0);
        chk("async_count", 32'(oCount), 0);
        chk("async_data", 32'(oData), 0);
        q.delete();
        rc = 0;
        ovf = 1'b0;
        @(negedge iClk);
        iRstN = 1'b1;

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 9) < 6, DW'($urandom), CNT_W'($urandom_range(0, 5)),
                $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
